// File: rtl/sound_event_sequencer.sv
// Game sound sequencer: queues single-cycle event pulses in a 4-deep FIFO and
// plays each as one or two timed square-wave notes, each followed by a silent gap.
module sound_event_sequencer #(
  parameter int unsigned PADDLE_HALF  = 56818,
  parameter int unsigned WALL_HALF    = 113636,
  parameter int unsigned SCORE_HALF_A = 28409,
  parameter int unsigned SCORE_HALF_B = 37879,
  parameter int unsigned DUR_CYCLES   = 8388608,
  parameter int unsigned GAP_CYCLES   = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit_paddle,
  input  logic       hit_wall,
  input  logic       score,
  input  logic       mute,
  input  logic       clr_dropped,
  output logic       speaker,
  output logic       busy,
  output logic       dropped,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {EV_PADDLE = 2'd0, EV_WALL = 2'd1, EV_SCORE = 2'd2} event_t;
  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [17:0] PADDLE_M1  = 18'(PADDLE_HALF - 1);
  localparam logic [17:0] WALL_M1    = 18'(WALL_HALF - 1);
  localparam logic [17:0] SCORE_A_M1 = 18'(SCORE_HALF_A - 1);
  localparam logic [17:0] SCORE_B_M1 = 18'(SCORE_HALF_B - 1);
  localparam logic [23:0] DUR_M1     = 24'(DUR_CYCLES - 1);
  localparam logic [23:0] GAP_M1     = 24'(GAP_CYCLES - 1);

  state_t      r_state;
  event_t      r_fifo [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_dropped;
  event_t      r_code;
  logic        r_note;
  logic [17:0] r_half_cnt;
  logic [23:0] r_dur_cnt;
  logic [23:0] r_gap_cnt;
  logic        r_spk;

  logic        w_any_ev;
  logic        w_multi_ev;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  event_t      w_ev_code;
  logic [17:0] w_half_m1;

  always_comb begin
    w_any_ev   = hit_paddle | hit_wall | score;
    w_multi_ev = (hit_paddle & hit_wall) | (hit_paddle & score) | (hit_wall & score);
    w_ev_code  = score ? EV_SCORE : (hit_paddle ? EV_PADDLE : EV_WALL);
    w_full     = (r_count == 3'd4);
    // Full is judged before any same-cycle pop, so a pop never makes room for a push.
    w_push     = w_any_ev & ~w_full;
    w_pop      = (r_state == IDLE) && (r_count != 3'd0);
    w_drop     = w_multi_ev | (w_any_ev & w_full);
    case (r_code)
      EV_WALL:  w_half_m1 = WALL_M1;
      EV_SCORE: w_half_m1 = r_note ? SCORE_B_M1 : SCORE_A_M1;
      default:  w_half_m1 = PADDLE_M1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_ev_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (!w_push && w_pop) r_count <= r_count - 3'd1;
      if (w_drop)           r_dropped <= 1'b1;
      else if (clr_dropped) r_dropped <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_code     <= EV_PADDLE;
      r_note     <= 1'b0;
      r_half_cnt <= '0;
      r_dur_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_spk      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_code     <= r_fifo[r_rd_ptr];
            r_note     <= 1'b0;
            r_half_cnt <= '0;
            r_dur_cnt  <= '0;
            r_spk      <= 1'b0;
            r_state    <= TONE;
          end
        end
        TONE: begin
          if (r_dur_cnt == DUR_M1) begin
            r_spk     <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else begin
            r_dur_cnt <= r_dur_cnt + 24'd1;
            if (r_half_cnt == w_half_m1) begin
              r_spk      <= ~r_spk;
              r_half_cnt <= '0;
            end else begin
              r_half_cnt <= r_half_cnt + 18'd1;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_M1) begin
            if (r_code == EV_SCORE && !r_note) begin
              r_note     <= 1'b1;
              r_half_cnt <= '0;
              r_dur_cnt  <= '0;
              r_state    <= TONE;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 24'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign speaker = r_spk & ~mute;
  assign busy    = (r_state != IDLE);
  assign dropped = r_dropped;
  assign pending = r_count;

endmodule
